vend_fsm_param: RTL and testbench

//   Parametrised vending-machine controller; successor to the fixed-price cola FSM.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_change_ser.sv | 41 ++++
 rtl/vend_fsm_param.sv | 127 ++++++++++++
 tb/tb_vend_fsm_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_pkg : shared types and coin weights for vend_fsm_param        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_ONE  = 2'd2;

  // Two coins in one cycle add both weights (max 3).
  function automatic logic [1:0] coin_weight(input logic half, input logic one);
    return (half ? W_HALF : 2'd0) + (one ? W_ONE : 2'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_ser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_change_ser : loadable down-counter emitting one pulse per unit |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vend_change_ser #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         pulse
);

  logic [W-1:0] r_cnt;
  logic         r_pulse;

  // The first pulse is issued on the load edge itself, so r_cnt holds the
  // pulses still owed after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (load) begin
      r_pulse <= (load_val != '0);
      r_cnt   <= (load_val != '0) ? load_val - W'(1) : '0;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - W'(1);
      r_pulse <= 1'b1;
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign busy  = (r_cnt != '0);
  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/vend_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_fsm_param : programmable-price vending controller with change |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE_HALF = 5,
  parameter int CREDIT_W   = $clog2(PRICE_HALF + 3)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_money,
  output logic                po_coin_rej,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
);

  localparam logic [CREDIT_W-1:0] c_price = CREDIT_W'(PRICE_HALF);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change;
  logic                r_cola;
  logic                r_rej;
  logic                r_busy;

  logic [CREDIT_W-1:0] w_weight;
  logic [CREDIT_W-1:0] w_sum;
  logic                w_open;
  logic                w_coin;
  logic                w_refund;
  logic                w_vend;
  logic                w_ser_load;
  logic [CREDIT_W-1:0] w_ser_val;
  logic                w_ser_busy;
  logic                w_money;

  assign w_weight = CREDIT_W'(coin_weight(pi_money_half, pi_money_one));
  assign w_sum    = r_credit + w_weight;
  assign w_open   = (r_state == IDLE) || (r_state == ACCUM);
  assign w_coin   = pi_money_half | pi_money_one;
  // A refund request takes priority over reaching the price on the same edge.
  assign w_refund = w_open && pi_cancel && (w_sum != '0);
  assign w_vend   = w_open && !w_refund && (w_sum >= c_price);

  // Vend change is held back one cycle so it trails the dispense pulse.
  assign w_ser_load = w_refund || ((r_state == VEND) && (r_change != '0));
  assign w_ser_val  = w_refund ? w_sum : r_change;

  vend_change_ser #(
    .W (CREDIT_W)
  ) u_change_ser (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (w_ser_load),
    .load_val (w_ser_val),
    .busy     (w_ser_busy),
    .pulse    (w_money)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_change <= '0;
      r_cola   <= 1'b0;
      r_rej    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cola <= 1'b0;
      r_rej  <= 1'b0;
      case (r_state)
        IDLE, ACCUM: begin
          if (w_refund) begin
            r_credit <= '0;
            r_busy   <= 1'b1;
            r_state  <= CHANGE;
          end else if (w_vend) begin
            r_change <= w_sum - c_price;
            r_credit <= '0;
            r_cola   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= VEND;
          end else begin
            r_credit <= w_sum;
            r_state  <= (w_sum != '0) ? ACCUM : IDLE;
          end
        end
        VEND: begin
          r_rej    <= w_coin;
          r_change <= '0;
          if (r_change != '0) begin
            r_state <= CHANGE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CHANGE: begin
          r_rej <= w_coin;
          if (!w_ser_busy) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign po_cola     = r_cola;
  assign po_money    = w_money;
  assign po_coin_rej = r_rej;
  assign po_busy     = r_busy;
  assign po_credit   = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vend_fsm_param : directed and soak bench for vend_fsm_param     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_vend_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       half, one, cancel;
  logic       half1, one1, cancel1;
  logic       cola, money, rej, busy;
  logic [2:0] credit;
  logic       cola1, money1, rej1, busy1;
  logic [1:0] credit1;

  int total = 0;
  int bad   = 0;

  // {cola, money, coin_rej, busy, credit}
  wire [6:0] obs  = {cola, money, rej, busy, credit};
  wire [5:0] obs1 = {cola1, money1, rej1, busy1, credit1};

  vend_fsm_param #(.PRICE_HALF(5)) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .pi_money_half (half),
    .pi_money_one  (one),
    .pi_cancel     (cancel),
    .po_cola       (cola),
    .po_money      (money),
    .po_coin_rej   (rej),
    .po_busy       (busy),
    .po_credit     (credit)
  );

  vend_fsm_param #(.PRICE_HALF(1)) dut1 (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .pi_money_half (half1),
    .pi_money_one  (one1),
    .pi_cancel     (cancel1),
    .po_cola       (cola1),
    .po_money      (money1),
    .po_coin_rej   (rej1),
    .po_busy       (busy1),
    .po_credit     (credit1)
  );

  task automatic cyc(input logic h, input logic o, input logic c);
    half = h; one = o; cancel = c;
    @(posedge clk); #1;
    half = 1'b0; one = 1'b0; cancel = 1'b0;
  endtask

  task automatic cyc1(input logic h, input logic o, input logic c);
    half1 = h; one1 = o; cancel1 = c;
    @(posedge clk); #1;
    half1 = 1'b0; one1 = 1'b0; cancel1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL reset_p5 got=%b want=%b", obs, 7'd0); end
    total++;
    if (obs1 !== 6'd0) begin bad++; $display("FAIL reset_p1 got=%b want=%b", obs1, 6'd0); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, 7'd0); end
  endtask

  // one, one, half: exact price, no change
  task automatic test_exact;
    logic [2:0] st [5] = '{3'b010, 3'b010, 3'b100, 3'b000, 3'b000};
    logic [6:0] ex [5] = '{7'b0000_010, 7'b0000_100, 7'b1001_000, 7'b0000_000, 7'b0000_000};
    for (int i = 0; i < 5; i++) begin
      cyc(st[i][2], st[i][1], st[i][0]);
      total++;
      if (obs !== ex[i]) begin bad++; $display("FAIL exact[%0d] got=%b want=%b", i, obs, ex[i]); end
    end
  endtask

  // one, one, one: vend then a single change pulse, busy for two cycles
  task automatic test_change1;
    logic [2:0] st [6] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [6] = '{7'b0000_010, 7'b0000_100, 7'b1001_000,
                           7'b0101_000, 7'b0000_000, 7'b0000_000};
    for (int i = 0; i < 6; i++) begin
      cyc(st[i][2], st[i][1], st[i][0]);
      total++;
      if (obs !== ex[i]) begin bad++; $display("FAIL change1[%0d] got=%b want=%b", i, obs, ex[i]); end
    end
  endtask

  // refund of 2, refund of 3, and cancel beating the price (refund of 6)
  task automatic test_cancel;
    logic [2:0] st [18] = '{3'b010, 3'b001, 3'b000, 3'b000,
                            3'b110, 3'b001, 3'b000, 3'b000, 3'b000,
                            3'b010, 3'b010, 3'b011, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex [18] = '{7'b0000_010, 7'b0101_000, 7'b0101_000, 7'b0000_000,
                            7'b0000_011, 7'b0101_000, 7'b0101_000, 7'b0101_000, 7'b0000_000,
                            7'b0000_010, 7'b0000_100, 7'b0101_000, 7'b0101_000, 7'b0101_000,
                            7'b0101_000, 7'b0101_000, 7'b0101_000, 7'b0000_000};
    for (int i = 0; i < 18; i++) begin
      cyc(st[i][2], st[i][1], st[i][0]);
      total++;
      if (obs !== ex[i]) begin bad++; $display("FAIL cancel[%0d] got=%b want=%b", i, obs, ex[i]); end
    end
    // cancel with no credit is ignored
    cyc(1'b0, 1'b0, 1'b1);
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL cancel_zero got=%b want=%b", obs, 7'd0); end
  endtask

  // coins while busy (CHANGE, then VEND with both coins) are rejected once
  task automatic test_reject;
    logic [2:0] st [10] = '{3'b010, 3'b001, 3'b110, 3'b000,
                            3'b010, 3'b010, 3'b010, 3'b110, 3'b000, 3'b000};
    logic [6:0] ex [10] = '{7'b0000_010, 7'b0101_000, 7'b0111_000, 7'b0000_000,
                            7'b0000_010, 7'b0000_100, 7'b1001_000, 7'b0111_000,
                            7'b0000_000, 7'b0000_000};
    for (int i = 0; i < 10; i++) begin
      cyc(st[i][2], st[i][1], st[i][0]);
      total++;
      if (obs !== ex[i]) begin bad++; $display("FAIL reject[%0d] got=%b want=%b", i, obs, ex[i]); end
    end
  endtask

  task automatic test_reset_mid_change;
    int n;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== 7'b0101_000) begin bad++; $display("FAIL midrst_pre got=%b want=%b", obs, 7'b0101_000); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL midrst_async got=%b want=%b", obs, 7'd0); end
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      n += int'(money);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", n); end
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL midrst_post got=%b want=%b", obs, 7'd0); end
  endtask

  task automatic test_price1;
    logic [2:0] st [10] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
                            3'b110, 3'b000, 3'b000, 3'b000};
    logic [5:0] ex [10] = '{6'b1001_00, 6'b0000_00, 6'b0000_00, 6'b1001_00, 6'b0101_00,
                            6'b0000_00, 6'b1001_00, 6'b0101_00, 6'b0101_00, 6'b0000_00};
    for (int i = 0; i < 10; i++) begin
      cyc1(st[i][2], st[i][1], st[i][0]);
      total++;
      if (obs1 !== ex[i]) begin bad++; $display("FAIL price1[%0d] got=%b want=%b", i, obs1, ex[i]); end
    end
  endtask

  task automatic test_soak;
    int   acc, vends, pulses, rej_exp, rej_seen, both, want;
    logic h, o, c;
    acc = 0; vends = 0; pulses = 0; rej_exp = 0; rej_seen = 0; both = 0;
    for (int i = 0; i < 10012; i++) begin
      if (i < 10000) begin
        h = 1'($urandom % 2);
        o = 1'($urandom % 2);
        c = (($urandom % 64) == 0);
      end else begin
        h = 1'b0; o = 1'b0; c = 1'b0;
      end
      if (busy) begin
        if (h || o) rej_exp++;
      end else begin
        acc += int'(h) + 2 * int'(o);
      end
      cyc(h, o, c);
      vends    += int'(cola);
      pulses   += int'(money);
      rej_seen += int'(rej);
      if (cola && money) both++;
    end
    want = 5 * vends + pulses + int'(credit);
    total++;
    if (acc !== want) begin bad++; $display("FAIL soak_conserve got=%0d want=%0d", want, acc); end
    total++;
    if (rej_seen !== rej_exp) begin bad++; $display("FAIL soak_rej got=%0d want=%0d", rej_seen, rej_exp); end
    total++;
    if (both !== 0) begin bad++; $display("FAIL soak_overlap got=%0d want=0", both); end
    total++;
    if (vends < 100) begin bad++; $display("FAIL soak_vends got=%0d want>=100", vends); end
  endtask

  initial begin
    rst_n = 1'b0;
    half = 1'b0; one = 1'b0; cancel = 1'b0;
    half1 = 1'b0; one1 = 1'b0; cancel1 = 1'b0;
    test_reset;
    test_exact;
    test_change1;
    test_cancel;
    test_reject;
    test_reset_mid_change;
    test_price1;
    test_soak;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
